// File: rtl/i2s_slave_frame_rx_pkg.sv
// Shared types and constants for the I2S slave frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_slave_frame_rx_pkg;

    localparam int MAX_BITS_DEF = 32;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_SEARCH,
        ST_MEASURE,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // A programmed lock count of zero behaves like one.
    function automatic logic [3:0] lock_target(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd1 : cfg;
    endfunction

endpackage

// File: rtl/i2s_slave_frame_rx_if.sv
// Pad, configuration and result bundle of the I2S slave frame receiver.
// Latency: n/a (wires only).
// Backpressure: none; every result is a strobe or a level with no ready.
interface i2s_slave_frame_rx_if #(
    parameter int MAX_BITS = i2s_slave_frame_rx_pkg::MAX_BITS_DEF
);
    localparam int WW = $clog2(MAX_BITS);

    logic                pad_sck_i;
    logic                pad_ws_i;
    logic                pad_sd_i;
    logic                cfg_en_i;
    logic [3:0]          cfg_lock_words_i;
    logic [15:0]         cfg_timeout_i;
    logic                sck_rise_o;
    logic [MAX_BITS-1:0] data_o;
    logic                data_ch_o;
    logic                data_valid_o;
    logic [WW-1:0]       word_size_o;
    logic                locked_o;
    logic                err_o;
    logic [1:0]          err_code_o;

    modport slave (
        input  pad_sck_i, pad_ws_i, pad_sd_i, cfg_en_i, cfg_lock_words_i, cfg_timeout_i,
        output sck_rise_o, data_o, data_ch_o, data_valid_o, word_size_o, locked_o,
               err_o, err_code_o
    );

    modport master (
        output pad_sck_i, pad_ws_i, pad_sd_i, cfg_en_i, cfg_lock_words_i, cfg_timeout_i,
        input  sck_rise_o, data_o, data_ch_o, data_valid_o, word_size_o, locked_o,
               err_o, err_code_o
    );

endinterface

// File: rtl/i2s_pad_edge_sync.sv
// Synchronizes one asynchronous pad and flags its 0->1 transitions.
// Latency: sync_o and rise_o follow the pad after SYNC_STAGES clk_i edges.
// Backpressure: none.
module i2s_pad_edge_sync
    import i2s_slave_frame_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain followed by a one-cycle history flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;

endmodule

// File: rtl/i2s_slave_frame_rx.sv
// I2S slave receiver: recovers words from external SCK/WS/SD, measures length, tracks lock.
// Latency: results register one cycle after the synchronized SCK rise (SYNC_STAGES+1 after the pad).
// Backpressure: none; data_valid_o/err_o are single-cycle strobes and must be consumed when seen.
module i2s_slave_frame_rx
    import i2s_slave_frame_rx_pkg::*;
#(
    parameter int MAX_BITS    = MAX_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    i2s_slave_frame_rx_if.slave  bus
);

    localparam int CW = $clog2(MAX_BITS + 2);
    localparam int WW = $clog2(MAX_BITS);

    logic sck_s, sck_rise, ws_s, ws_rise, sd_s, sd_rise;
    logic unused_rise;

    i2s_pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(clk_i), .rst_i(rst_i), .pad_i(bus.pad_sck_i), .sync_o(sck_s), .rise_o(sck_rise)
    );
    i2s_pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk_i(clk_i), .rst_i(rst_i), .pad_i(bus.pad_ws_i), .sync_o(ws_s), .rise_o(ws_rise)
    );
    i2s_pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
        .clk_i(clk_i), .rst_i(rst_i), .pad_i(bus.pad_sd_i), .sync_o(sd_s), .rise_o(sd_rise)
    );

    // Only the SCK edge matters; WS and SD are sampled as levels at that edge.
    assign unused_rise = ws_rise | sd_rise | sck_s;

    // Bit datapath
    logic [MAX_BITS-1:0] shift_q, shift_nxt, word_mask, word_dat;
    logic [CW-1:0]       cnt_q, cnt_inc;
    logic                ws_prev_q;
    logic [15:0]         idle_q, idle_nxt;
    logic                boundary, ovf, tmo;

    assign shift_nxt = {shift_q[MAX_BITS-2:0], sd_s};
    assign cnt_inc   = (cnt_q == CW'(MAX_BITS + 1)) ? cnt_q : cnt_q + CW'(1);
    // cnt_inc includes the current rise, so it is the length of a word ending here.
    assign word_mask = (cnt_inc >= CW'(MAX_BITS)) ? '1
                     : ((MAX_BITS'(1) << cnt_inc) - MAX_BITS'(1));
    assign word_dat  = shift_nxt & word_mask;
    assign boundary  = sck_rise && (ws_s != ws_prev_q);
    assign idle_nxt  = sck_rise ? 16'd0 : ((&idle_q) ? idle_q : idle_q + 16'd1);
    assign ovf       = sck_rise && ((cnt_inc > CW'(MAX_BITS)) || (boundary && (cnt_inc < CW'(2))));
    assign tmo       = (bus.cfg_timeout_i != 16'd0) && (idle_nxt == bus.cfg_timeout_i);

    // Shift register, bit counter, WS history and idle timer advance on SCK rises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            ws_prev_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            idle_q <= idle_nxt;
            if (sck_rise) begin
                shift_q   <= shift_nxt;
                ws_prev_q <= ws_s;
                cnt_q     <= boundary ? '0 : cnt_inc;
            end
        end
    end

    // Frame FSM and registered outputs
    state_t              state_q, state_nxt;
    logic [CW-1:0]       ref_q, ref_nxt;
    logic [3:0]          match_q, match_nxt;
    logic                locked_q, locked_nxt;
    logic [MAX_BITS-1:0] dat_q, dat_nxt;
    logic                ch_q, ch_nxt, vld_q, vld_nxt, err_q, err_nxt, rise_q, rise_nxt;
    logic [1:0]          code_q, code_nxt;
    logic                lock_reached;

    assign lock_reached = ({1'b0, match_q} + 5'd1) >= {1'b0, lock_target(bus.cfg_lock_words_i)};

    // Next-state and next-output decode; overflow beats boundary beats timeout.
    always_comb begin
        state_nxt  = state_q;
        ref_nxt    = ref_q;
        match_nxt  = match_q;
        locked_nxt = locked_q;
        dat_nxt    = dat_q;
        ch_nxt     = ch_q;
        vld_nxt    = 1'b0;
        err_nxt    = 1'b0;
        code_nxt   = code_q;
        rise_nxt   = sck_rise;
        unique case (state_q)
            ST_DISABLED: begin
                rise_nxt  = 1'b0;
                state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (boundary) state_nxt = ST_MEASURE;
            end
            ST_MEASURE, ST_TRACK, ST_LOCKED: begin
                if (ovf) begin
                    err_nxt    = 1'b1;
                    code_nxt   = ERR_OVF;
                    locked_nxt = 1'b0;
                    state_nxt  = ST_SEARCH;
                end else if (boundary) begin
                    if (state_q == ST_MEASURE) begin
                        ref_nxt   = cnt_inc;
                        match_nxt = 4'd1;
                        vld_nxt   = 1'b1;
                        state_nxt = ST_TRACK;
                    end else if (cnt_inc == ref_q) begin
                        vld_nxt = 1'b1;
                        if (state_q == ST_TRACK) begin
                            if (lock_reached) begin
                                locked_nxt = 1'b1;
                                state_nxt  = ST_LOCKED;
                            end else begin
                                match_nxt = match_q + 4'd1;
                            end
                        end
                    end else begin
                        err_nxt    = 1'b1;
                        code_nxt   = ERR_LEN;
                        ref_nxt    = cnt_inc;
                        match_nxt  = 4'd1;
                        locked_nxt = 1'b0;
                        state_nxt  = ST_TRACK;
                    end
                end else if (tmo) begin
                    err_nxt    = 1'b1;
                    code_nxt   = ERR_TMO;
                    locked_nxt = 1'b0;
                    state_nxt  = ST_SEARCH;
                end
            end
            default: state_nxt = ST_DISABLED;
        endcase
        if (vld_nxt) begin
            dat_nxt = word_dat;
            ch_nxt  = ws_prev_q;
        end
        // Dropping the enable silently clears everything, including the held error code.
        if (!bus.cfg_en_i) begin
            state_nxt  = ST_DISABLED;
            ref_nxt    = '0;
            match_nxt  = '0;
            locked_nxt = 1'b0;
            dat_nxt    = '0;
            ch_nxt     = 1'b0;
            vld_nxt    = 1'b0;
            err_nxt    = 1'b0;
            code_nxt   = ERR_NONE;
            rise_nxt   = 1'b0;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_DISABLED;
            ref_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
            dat_q    <= '0;
            ch_q     <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            rise_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ref_q    <= ref_nxt;
            match_q  <= match_nxt;
            locked_q <= locked_nxt;
            dat_q    <= dat_nxt;
            ch_q     <= ch_nxt;
            vld_q    <= vld_nxt;
            err_q    <= err_nxt;
            code_q   <= code_nxt;
            rise_q   <= rise_nxt;
        end
    end

    assign bus.sck_rise_o   = rise_q;
    assign bus.data_o       = dat_q;
    assign bus.data_ch_o    = ch_q;
    assign bus.data_valid_o = vld_q;
    assign bus.word_size_o  = locked_q ? WW'(ref_q - CW'(1)) : '0;
    assign bus.locked_o     = locked_q;
    assign bus.err_o        = err_q;
    assign bus.err_code_o   = code_q;

endmodule

// File: doc/i2s_slave_frame_rx.md
# i2s_slave_frame_rx

Receive-side counterpart of the I2S SCK/WS generator. Operates entirely in the system clock domain: oversamples externally driven SCK, WS and SD pad inputs, recovers word boundaries from WS transitions, measures the word length, reports lock, and delivers received words with their channel tag. Sits between the I2S pads and the uDMA RX datapath whenever the peripheral is clocked by an external master.

## Interface
- MAX_BITS, 32, maximum supported word length in bits; sets the width of the data and counter paths.
- SYNC_STAGES, 2, synchronizer depth on each pad input.

- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- pad_sck_i  in  1  external SCK, asynchronous to clk_i
- pad_ws_i  in  1  external WS, asynchronous
- pad_sd_i  in  1  external serial data, asynchronous
- cfg_en_i  in  1  block enable; low forces DISABLED
- cfg_lock_words_i  in  4  consecutive matching words required for lock; 0 is treated as 1
- cfg_timeout_i  in  16  clk_i cycles allowed without an SCK rise before a timeout; 0 disables the timeout
- sck_rise_o  out  1  one-cycle pulse per detected SCK rising edge
- data_o  out  32  received word, right-aligned, upper bits zero
- data_ch_o  out  1  channel of data_o (WS level during that word: 0 = left, 1 = right)
- data_valid_o  out  1  one-cycle strobe qualifying data_o and data_ch_o
- word_size_o  out  5  measured word length minus 1; meaningful only while locked_o is high
- locked_o  out  1  word length is stable
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  error code, held until the next err_o: 01 length mismatch, 10 overflow, 11 timeout

## Operation
- Each pad input passes through SYNC_STAGES flops plus one history flop. An SCK rise is a synchronized 0→1 transition. At each rise r, sample ws_r and sd_r.
- Shift register: on every rise, shift sd_r in at the LSB (MSB-first reception). The bit counter increments per rise and saturates at MAX_BITS+1.
- A word boundary occurs at rise r when ws_r != ws_(r-1). The completed word spans the rises after the previous boundary up to and including r, so the LSB arrives on the WS-change rise (standard one-bit I2S delay). At the boundary:
  - The completed word has length n = counter.
  - Channel = ws_(r-1).
  - The counter resets to 0.
- FSM states:
  - DISABLED: outputs cleared. Go to SEARCH when cfg_en_i is high.
  - SEARCH: wait for the first boundary, then go to MEASURE. No data_valid_o is produced.
  - MEASURE: at the next boundary, store n as the reference length and go to TRACK with match count 1. Emit data_valid_o.
  - TRACK: at each boundary, if n equals the reference, increment the match count and emit data. Go to LOCKED when the match count reaches max(cfg_lock_words_i, 1). Otherwise, raise error 01, store n as the new reference, and reset the match count to 1.
  - LOCKED: locked_o is high and word_size_o = reference − 1. A mismatch raises error 01, clears locked_o, stores the new reference, and moves to TRACK.
- Overflow: if the counter exceeds MAX_BITS in MEASURE, TRACK or LOCKED, raise error 10, clear lock, and go to SEARCH. A boundary with n < 2 is also treated as overflow (error 10).
- Timeout: an idle counter resets on each SCK rise. If it reaches a nonzero cfg_timeout_i in MEASURE, TRACK or LOCKED, raise error 11, clear lock, and go to SEARCH.
- Simultaneous events: timeout and a boundary in the same cycle resolve as the boundary (the rise resets the timer). Overflow takes priority over mismatch.
- cfg_en_i low in any state: go to DISABLED on the next cycle. No error is raised.

## Timing
- Reset (rst_i high at a clk_i edge): state DISABLED. All outputs are 0 on the following cycle, including err_code_o = 00. Counters, shift register and history flops are cleared. Reset mid-word drops the partial word.
- Latency: sck_rise_o asserts SYNC_STAGES+1 cycles after the pad SCK rise. data_valid_o, err_o and the locked_o update occur in the same cycle as the sck_rise_o of the boundary rise.
- SCK high and low phases must each last at least SYNC_STAGES+1 clk_i cycles. Faster SCK is out of specification.
- Error pulses last exactly 1 cycle. At most one error is raised per cycle.

## Structure
- Package i2s_slave_frame_rx_pkg holds:
  - FSM state enum (DISABLED, SEARCH, MEASURE, TRACK, LOCKED)
  - error code constants
  - the MAX_BITS default
- Sub-module i2s_pad_edge_sync: synchronizer plus history flop for one pad, with a rise-pulse output. Instantiated three times.

## Test plan
- Lock: 16-bit stereo frames with cfg_lock_words_i = 3. Expect locked_o after the 4th boundary (MEASURE + 3 matches), word_size_o = 15, data_o words match stimulus, data_ch_o alternating 0/1.
- Mismatch: lock on 24-bit words, then send one 20-bit word. Expect err_o with code 01 and locked_o low. Relock to 20 bits after the programmed count.
- Overflow: hold WS constant for 40 SCK rises after lock. Expect err code 10 at rise 33 and the FSM in SEARCH.
- Timeout: cfg_timeout_i = 100, stop SCK while locked. Expect err code 11 exactly 100 cycles after the last sck_rise_o.
- Reset/disable mid-word: assert rst_i at bit 7 of a 32-bit word. Expect all outputs 0 on the next cycle, no data_valid_o for the truncated word, and clean relock afterward. Repeat the scenario with cfg_en_i dropped instead of rst_i.
